// File: rtl/piso_ctrl_pkg.sv
// Shared types and helpers for the PISO serializer controller.
package piso_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// WIDTH-bit shift register and serial output flop, MSB first.
module piso_shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_serial
);

  logic [WIDTH-1:0] r_shift;
  logic             r_serial;

  // Clear wins over load, so an abort never lets a new word slip in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift  <= '0;
      r_serial <= 1'b0;
    end else if (i_clear) begin
      r_shift  <= '0;
      r_serial <= 1'b0;
    end else if (i_load) begin
      r_shift  <= {i_data[WIDTH-2:0], 1'b0};
      r_serial <= i_data[WIDTH-1];
    end else if (i_shift) begin
      r_shift  <= {r_shift[WIDTH-2:0], 1'b0};
      r_serial <= r_shift[WIDTH-1];
    end
  end

  assign o_serial = r_serial;

endmodule

// File: rtl/piso_serializer_ctrl.sv
// Handshaked load/shift sequencer for a PISO register with framing strobes,
// abort, and a programmable idle gap after each frame.
module piso_serializer_ctrl
  import piso_ctrl_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy,
  output logic             done
);

  localparam int BW = cnt_width(WIDTH);
  localparam int GW = cnt_width(GAP_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam state_e END_STATE = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_e          r_state, w_state_next;
  logic [BW-1:0]   r_bit_cnt, w_bit_cnt_next;
  logic [GW-1:0]   r_gap_cnt, w_gap_cnt_next;
  logic            r_serial_valid, w_serial_valid_next;
  logic            r_frame_start, w_frame_start_next;
  logic            r_frame_last, w_frame_last_next;
  logic            r_done, w_done_next;
  logic            r_busy;
  logic            w_handshake;
  logic            w_load, w_shift, w_clear;

  assign in_ready    = (r_state == IDLE) && !abort && !rst;
  assign w_handshake = in_valid && in_ready;

  always_comb begin
    w_state_next        = r_state;
    w_bit_cnt_next      = r_bit_cnt;
    w_gap_cnt_next      = r_gap_cnt;
    w_serial_valid_next = 1'b0;
    w_frame_start_next  = 1'b0;
    w_frame_last_next   = 1'b0;
    w_done_next         = 1'b0;
    w_load              = 1'b0;
    w_shift             = 1'b0;
    w_clear             = 1'b0;

    if (abort) begin
      w_state_next   = IDLE;
      w_bit_cnt_next = '0;
      w_gap_cnt_next = '0;
      w_clear        = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_handshake) begin
            w_load              = 1'b1;
            w_serial_valid_next = 1'b1;
            w_frame_start_next  = 1'b1;
            w_bit_cnt_next      = '0;
            w_state_next        = SHIFT;
          end
        end
        SHIFT: begin
          if (r_bit_cnt == BIT_LAST) begin
            // Clearing here drops serial_out to 0 alongside serial_valid.
            w_clear        = 1'b1;
            w_done_next    = 1'b1;
            w_bit_cnt_next = '0;
            w_gap_cnt_next = '0;
            w_state_next   = END_STATE;
          end else begin
            w_shift             = 1'b1;
            w_serial_valid_next = 1'b1;
            w_bit_cnt_next      = r_bit_cnt + 1'b1;
            w_frame_last_next   = ((r_bit_cnt + 1'b1) == BIT_LAST);
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            w_gap_cnt_next = '0;
            w_state_next   = IDLE;
          end else begin
            w_gap_cnt_next = r_gap_cnt + 1'b1;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_clear      = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_bit_cnt      <= '0;
      r_gap_cnt      <= '0;
      r_serial_valid <= 1'b0;
      r_frame_start  <= 1'b0;
      r_frame_last   <= 1'b0;
      r_done         <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_bit_cnt      <= w_bit_cnt_next;
      r_gap_cnt      <= w_gap_cnt_next;
      r_serial_valid <= w_serial_valid_next;
      r_frame_start  <= w_frame_start_next;
      r_frame_last   <= w_frame_last_next;
      r_done         <= w_done_next;
      r_busy         <= (w_state_next != IDLE);
    end
  end

  piso_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_shift  (w_shift),
    .i_clear  (w_clear),
    .i_data   (in_data),
    .o_serial (serial_out)
  );

  assign serial_valid = r_serial_valid;
  assign frame_start  = r_frame_start;
  assign frame_last   = r_frame_last;
  assign done         = r_done;
  assign busy         = r_busy;

endmodule

// File: tb/tb_piso_serializer_ctrl.sv
// Bench for piso_serializer_ctrl: two instances (GAP_CYCLES=1 and 0) checked
// against a frame-timeline model derived from handshake times.
module tb_piso_serializer_ctrl;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]   iv, ab, rdy, sv, so, fs, fl, by, dn;
  logic [W-1:0] id [2];

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] words [8];
  int gaps [2] = '{1, 0};

  piso_serializer_ctrl #(.WIDTH(W), .GAP_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id[0]), .in_ready(rdy[0]),
    .abort(ab[0]), .serial_out(so[0]), .serial_valid(sv[0]), .frame_start(fs[0]),
    .frame_last(fl[0]), .busy(by[0]), .done(dn[0])
  );

  piso_serializer_ctrl #(.WIDTH(W), .GAP_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id[1]), .in_ready(rdy[1]),
    .abort(ab[1]), .serial_out(so[1]), .serial_valid(sv[1]), .frame_start(fs[1]),
    .frame_last(fl[1]), .busy(by[1]), .done(dn[1])
  );

  task automatic chk(input string tag, input int d, input int c, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s dut%0d cyc%0d: observed %b expected %b", tag, d, c, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int d, input int c, input logic exp_rdy);
    chk({tag, "_sv"}, d, c, sv[d], 1'b0);
    chk({tag, "_so"}, d, c, so[d], 1'b0);
    chk({tag, "_fs"}, d, c, fs[d], 1'b0);
    chk({tag, "_fl"}, d, c, fl[d], 1'b0);
    chk({tag, "_busy"}, d, c, by[d], 1'b0);
    chk({tag, "_done"}, d, c, dn[d], 1'b0);
    chk({tag, "_rdy"}, d, c, rdy[d], exp_rdy);
  endtask

  // Continuous in_valid over words[0..n-1]; frame i handshakes at cycle
  // i*(W+gap+1), bits follow in the next W cycles, done right after.
  task automatic run_scn(input int d, input int n);
    int g, per, last_c;
    g      = gaps[d];
    per    = W + g + 1;
    last_c = (n - 1) * per + W + g + 2;
    for (int c = 0; c <= last_c; c++) begin
      int fi, k, nxt;
      logic edone, ebusy, eso;
      logic [W-1:0] wv;
      fi = -1; k = 0; nxt = -1; edone = 1'b0; ebusy = 1'b0; eso = 1'b0;
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
        int t;
        t = i * per;
        if (c > t && c <= t + W) begin fi = i; k = c - t - 1; end
        if (c == t + W + 1) edone = 1'b1;
        if (c > t && c <= t + W + g) ebusy = 1'b1;
        if (nxt < 0 && t >= c) nxt = i;
      end
      if (fi >= 0) begin
        wv  = words[fi];
        eso = wv[W-1-k];
      end
      chk("sv", d, c, sv[d], fi >= 0);
      chk("so", d, c, so[d], eso);
      chk("fs", d, c, fs[d], fi >= 0 && k == 0);
      chk("fl", d, c, fl[d], fi >= 0 && k == W - 1);
      chk("done", d, c, dn[d], edone);
      chk("busy", d, c, by[d], ebusy);
      chk("rdy", d, c, rdy[d], !ebusy);
      iv[d] = (nxt >= 0);
      id[d] = (nxt >= 0) ? words[nxt] : W'($urandom);
    end
    iv[d] = 1'b0;
  endtask

  task automatic abort_scn(input int d, input logic [W-1:0] word, input int kbit);
    @(negedge clk);
    chk("ab_rdy0", d, 0, rdy[d], 1'b1);
    iv[d] = 1'b1;
    id[d] = word;
    for (int c = 1; c <= kbit + 1; c++) begin
      @(negedge clk);
      iv[d] = 1'b0;
      id[d] = W'($urandom);
      chk("ab_sv", d, c, sv[d], 1'b1);
      chk("ab_so", d, c, so[d], word[W-c]);
    end
    ab[d] = 1'b1;
    #1 chk("ab_rdy_hold", d, kbit + 1, rdy[d], 1'b0);
    @(negedge clk);
    ab[d] = 1'b0;
    #1 chk_idle("ab_after", d, kbit + 2, 1'b1);
    for (int c = 0; c < W + gaps[d] + 1; c++) begin
      @(negedge clk);
      chk("ab_nodone", d, kbit + 3 + c, dn[d], 1'b0);
      chk("ab_nosv", d, kbit + 3 + c, sv[d], 1'b0);
    end
  endtask

  task automatic abort_idle_scn(input int d);
    @(negedge clk);
    iv[d] = 1'b1;
    ab[d] = 1'b1;
    id[d] = W'($urandom);
    #1 chk("abidle_rdy", d, 0, rdy[d], 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("abidle_sv", d, c, sv[d], 1'b0);
      chk("abidle_busy", d, c, by[d], 1'b0);
    end
    iv[d] = 1'b0;
    ab[d] = 1'b0;
  endtask

  task automatic rst_scn(input int d);
    @(negedge clk);
    iv[d] = 1'b1;
    id[d] = 4'b1101;
    @(negedge clk);
    iv[d] = 1'b0;
    chk("rst_pre_sv", d, 1, sv[d], 1'b1);
    @(negedge clk);
    chk("rst_pre_so", d, 2, so[d], 1'b1);
    iv[d] = 1'b1;
    #1 rst = 1'b1;
    #1 chk_idle("rst_async", d, 2, 1'b0);
    for (int c = 3; c <= 4; c++) begin
      @(negedge clk);
      chk_idle("rst_hold", d, c, 1'b0);
    end
    iv[d] = 1'b0;
    rst = 1'b0;
    words[0] = 4'b1001;
    run_scn(d, 1);
  endtask

  initial begin
    rst = 1'b1;
    iv  = '0;
    ab  = '0;
    id[0] = '0;
    id[1] = '0;
    #1;
    for (int d = 0; d < 2; d++) chk_idle("reset", d, 0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk_idle("post_reset", d, 0, 1'b1);

    for (int d = 0; d < 2; d++) begin
      words[0] = 4'b1101;
      run_scn(d, 1);
      words[0] = 4'b1010;
      words[1] = 4'b0110;
      run_scn(d, 2);
    end

    for (int r = 0; r < 4; r++) begin
      for (int d = 0; d < 2; d++) begin
        int n;
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) words[i] = W'($urandom);
        run_scn(d, n);
      end
    end

    for (int d = 0; d < 2; d++) begin
      abort_scn(d, 4'b1111, 1);
      words[0] = 4'b0001;
      run_scn(d, 1);
      for (int r = 0; r < 3; r++) begin
        abort_scn(d, W'($urandom), $urandom_range(0, W - 1));
        words[0] = W'($urandom);
        words[1] = W'($urandom);
        run_scn(d, 2);
      end
      abort_idle_scn(d);
      words[0] = W'($urandom);
      run_scn(d, 1);
    end

    for (int d = 0; d < 2; d++) rst_scn(d);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
